// File: rtl/alu_execute_unit.sv
// Execute stage of a single-cycle MIPS-style datapath.
// Contains the operand-B mux, the ALU-control decode, a 32-bit ALU and a registered trace copy of the flags.
module alu_execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [5:0]       Funct,
  input  logic [3:0]       AluOp,
  input  logic             AluSrc,
  input  logic [WIDTH-1:0] Read_Data1,
  input  logic [WIDTH-1:0] Read_Data2,
  input  logic [WIDTH-1:0] Extention_out,
  output logic [3:0]       AluAddress,
  output logic [WIDTH-1:0] Operand_B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] Result_q,
  output logic             Zero_q,
  output logic             Overflow_q
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  logic [WIDTH-1:0] a_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             overflow_d;

  assign a_s       = Read_Data1;
  assign shamt_s   = Read_Data1[SHW-1:0];
  assign Operand_B = AluSrc ? Extention_out : Read_Data2;

  // ALU-control decode: AluOp class, with R-type resolved through Funct
  always_comb begin
    AluAddress = ALU_ADD;
    case (AluOp)
      4'b0000: AluAddress = ALU_ADD;
      4'b0001: AluAddress = ALU_SUB;
      4'b0010: begin
        case (Funct)
          6'b100000, 6'b100001: AluAddress = ALU_ADD;
          6'b100010, 6'b100011: AluAddress = ALU_SUB;
          6'b100100: AluAddress = ALU_AND;
          6'b100101: AluAddress = ALU_OR;
          6'b100110: AluAddress = ALU_XOR;
          6'b100111: AluAddress = ALU_NOR;
          6'b101010: AluAddress = ALU_SLT;
          6'b101011: AluAddress = ALU_SLTU;
          6'b000100: AluAddress = ALU_SLL;
          6'b000110: AluAddress = ALU_SRL;
          6'b000111: AluAddress = ALU_SRA;
          default:   AluAddress = ALU_ADD;
        endcase
      end
      4'b0011: AluAddress = ALU_AND;
      4'b0100: AluAddress = ALU_OR;
      4'b0101: AluAddress = ALU_SLT;
      4'b0110: AluAddress = ALU_XOR;
      4'b0111: AluAddress = ALU_LUI;
      default: AluAddress = ALU_ADD;
    endcase
  end

  // ALU datapath; overflow is a flag only, ADD/SUB always wrap
  always_comb begin
    result_d   = {WIDTH{1'b0}};
    overflow_d = 1'b0;
    case (AluAddress)
      ALU_AND:  result_d = a_s & Operand_B;
      ALU_OR:   result_d = a_s | Operand_B;
      ALU_ADD: begin
        result_d   = a_s + Operand_B;
        overflow_d = (a_s[WIDTH-1] == Operand_B[WIDTH-1]) && (result_d[WIDTH-1] != a_s[WIDTH-1]);
      end
      ALU_XOR:  result_d = a_s ^ Operand_B;
      ALU_SUB: begin
        result_d   = a_s - Operand_B;
        overflow_d = (a_s[WIDTH-1] != Operand_B[WIDTH-1]) && (result_d[WIDTH-1] != a_s[WIDTH-1]);
      end
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a_s) < $signed(Operand_B))};
      ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a_s < Operand_B)};
      ALU_SLL:  result_d = Operand_B << shamt_s;
      ALU_SRL:  result_d = Operand_B >> shamt_s;
      ALU_SRA:  result_d = $unsigned($signed(Operand_B) >>> shamt_s);
      ALU_NOR:  result_d = ~(a_s | Operand_B);
      ALU_LUI:  result_d = {Operand_B[15:0], {(WIDTH-16){1'b0}}};
      default: begin
        result_d   = {WIDTH{1'b0}};
        overflow_d = 1'b0;
      end
    endcase
  end

  assign zero_d   = (result_d == {WIDTH{1'b0}});
  assign Result   = result_d;
  assign Zero     = zero_d;
  assign Overflow = overflow_d;

  // Trace registers, one cycle behind the combinational outputs
  always_ff @(posedge clk) begin
    if (Reset) begin
      Result_q   <= {WIDTH{1'b0}};
      Zero_q     <= 1'b0;
      Overflow_q <= 1'b0;
    end else begin
      Result_q   <= result_d;
      Zero_q     <= zero_d;
      Overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed self-checking bench for alu_execute_unit; expected values are hand-computed.
module tb_alu_execute_unit;

  logic        clk;
  logic        Reset;
  logic [5:0]  Funct;
  logic [3:0]  AluOp;
  logic        AluSrc;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic [31:0] Extention_out;
  logic [3:0]  AluAddress;
  logic [31:0] Operand_B;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic [31:0] Result_q;
  logic        Zero_q;
  logic        Overflow_q;

  int checks;
  int fails;

  alu_execute_unit #(.WIDTH(32)) dut (
    .clk(clk), .Reset(Reset), .Funct(Funct), .AluOp(AluOp), .AluSrc(AluSrc),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2), .Extention_out(Extention_out),
    .AluAddress(AluAddress), .Operand_B(Operand_B), .Result(Result), .Zero(Zero),
    .Overflow(Overflow), .Result_q(Result_q), .Zero_q(Zero_q), .Overflow_q(Overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [5:0] f, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext);
    AluOp = op; Funct = f; AluSrc = src;
    Read_Data1 = a; Read_Data2 = b; Extention_out = ext;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    Reset = 1'b1;
    drive(4'b0000, 6'b000000, 1'b0, 32'd5, 32'd2, 32'd0);
    checks++;
    if (Result !== 32'd7) begin fails++; $display("FAIL reset_comb got=%h exp=%h", Result, 32'd7); end
    @(posedge clk); #1;
    checks++;
    if (Result_q !== 32'd0 || Zero_q !== 1'b0 || Overflow_q !== 1'b0) begin
      fails++; $display("FAIL reset_regs got=%h/%b/%b exp=0/0/0", Result_q, Zero_q, Overflow_q);
    end
    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Result_q !== 32'd7 || Zero_q !== 1'b0) begin
      fails++; $display("FAIL release_regs got=%h/%b exp=7/0", Result_q, Zero_q);
    end
  endtask

  task automatic test_rtype;
    drive(4'b0010, 6'b100000, 1'b0, 32'd5, 32'd3, 32'd0);
    checks++;
    if (AluAddress !== 4'b0010 || Result !== 32'd8 || Zero !== 1'b0) begin
      fails++; $display("FAIL rtype_add got=%b/%h/%b exp=0010/8/0", AluAddress, Result, Zero);
    end
    drive(4'b0010, 6'b100010, 1'b0, 32'd3, 32'd3, 32'd0);
    checks++;
    if (AluAddress !== 4'b0110 || Result !== 32'd0 || Zero !== 1'b1) begin
      fails++; $display("FAIL rtype_sub got=%b/%h/%b exp=0110/0/1", AluAddress, Result, Zero);
    end
    drive(4'b0010, 6'b100001, 1'b0, 32'd10, 32'd20, 32'd0);
    checks++;
    if (Result !== 32'd30) begin fails++; $display("FAIL rtype_addu got=%h exp=%h", Result, 32'd30); end
    drive(4'b0010, 6'b100100, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    checks++;
    if (AluAddress !== 4'b0000 || Result !== 32'h0000F000) begin
      fails++; $display("FAIL rtype_and got=%b/%h exp=0000/0000f000", AluAddress, Result);
    end
    drive(4'b0010, 6'b100101, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    checks++;
    if (AluAddress !== 4'b0001 || Result !== 32'h0000FFF0) begin
      fails++; $display("FAIL rtype_or got=%b/%h exp=0001/0000fff0", AluAddress, Result);
    end
    drive(4'b0010, 6'b100110, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    checks++;
    if (AluAddress !== 4'b0011 || Result !== 32'h00000FF0) begin
      fails++; $display("FAIL rtype_xor got=%b/%h exp=0011/00000ff0", AluAddress, Result);
    end
    drive(4'b0010, 6'b100111, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    checks++;
    if (AluAddress !== 4'b1100 || Result !== 32'hFFFF000F) begin
      fails++; $display("FAIL rtype_nor got=%b/%h exp=1100/ffff000f", AluAddress, Result);
    end
  endtask

  task automatic test_immediate;
    drive(4'b0000, 6'b000000, 1'b1, 32'h00000100, 32'h00000055, 32'hFFFFFFFC);
    checks++;
    if (Operand_B !== 32'hFFFFFFFC || Result !== 32'h000000FC || AluAddress !== 4'b0010) begin
      fails++; $display("FAIL imm_add got=%h/%h/%b exp=fffffffc/000000fc/0010", Operand_B, Result, AluAddress);
    end
    drive(4'b0000, 6'b000000, 1'b0, 32'h00000100, 32'h00000055, 32'hFFFFFFFC);
    checks++;
    if (Operand_B !== 32'h00000055 || Result !== 32'h00000155) begin
      fails++; $display("FAIL reg_add got=%h/%h exp=00000055/00000155", Operand_B, Result);
    end
  endtask

  task automatic test_overflow;
    drive(4'b0000, 6'b000000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'd0);
    checks++;
    if (Result !== 32'h80000000 || Overflow !== 1'b1) begin
      fails++; $display("FAIL add_ovf got=%h/%b exp=80000000/1", Result, Overflow);
    end
    @(posedge clk); #1;
    checks++;
    if (Result_q !== 32'h80000000 || Overflow_q !== 1'b1 || Zero_q !== 1'b0) begin
      fails++; $display("FAIL add_ovf_q got=%h/%b/%b exp=80000000/1/0", Result_q, Overflow_q, Zero_q);
    end
    drive(4'b0001, 6'b000000, 1'b0, 32'h80000000, 32'h00000001, 32'd0);
    checks++;
    if (AluAddress !== 4'b0110 || Result !== 32'h7FFFFFFF || Overflow !== 1'b1) begin
      fails++; $display("FAIL sub_ovf got=%b/%h/%b exp=0110/7fffffff/1", AluAddress, Result, Overflow);
    end
    drive(4'b0011, 6'b000000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'd0);
    checks++;
    if (AluAddress !== 4'b0000 || Result !== 32'h00000001 || Overflow !== 1'b0) begin
      fails++; $display("FAIL and_noovf got=%b/%h/%b exp=0000/1/0", AluAddress, Result, Overflow);
    end
    drive(4'b0000, 6'b000000, 1'b0, 32'h00000005, 32'hFFFFFFFB, 32'd0);
    checks++;
    if (Result !== 32'd0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
      fails++; $display("FAIL add_wrap_zero got=%h/%b/%b exp=0/1/0", Result, Zero, Overflow);
    end
  endtask

  task automatic test_compare;
    drive(4'b0010, 6'b101010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'd0);
    checks++;
    if (AluAddress !== 4'b0111 || Result !== 32'd1 || Zero !== 1'b0) begin
      fails++; $display("FAIL slt got=%b/%h/%b exp=0111/1/0", AluAddress, Result, Zero);
    end
    drive(4'b0010, 6'b101011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'd0);
    checks++;
    if (AluAddress !== 4'b1000 || Result !== 32'd0 || Zero !== 1'b1) begin
      fails++; $display("FAIL sltu got=%b/%h/%b exp=1000/0/1", AluAddress, Result, Zero);
    end
    drive(4'b0101, 6'b000000, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'd0);
    checks++;
    if (Result !== 32'd0) begin fails++; $display("FAIL slt_op got=%h exp=0", Result); end
  endtask

  task automatic test_shift;
    drive(4'b0010, 6'b000111, 1'b0, 32'd4, 32'h80000000, 32'd0);
    checks++;
    if (AluAddress !== 4'b1011 || Result !== 32'hF8000000) begin
      fails++; $display("FAIL sra got=%b/%h exp=1011/f8000000", AluAddress, Result);
    end
    drive(4'b0010, 6'b000110, 1'b0, 32'd4, 32'h80000000, 32'd0);
    checks++;
    if (AluAddress !== 4'b1010 || Result !== 32'h08000000) begin
      fails++; $display("FAIL srl got=%b/%h exp=1010/08000000", AluAddress, Result);
    end
    drive(4'b0010, 6'b000100, 1'b0, 32'd4, 32'h00000001, 32'd0);
    checks++;
    if (AluAddress !== 4'b1001 || Result !== 32'h00000010) begin
      fails++; $display("FAIL sll got=%b/%h exp=1001/00000010", AluAddress, Result);
    end
    drive(4'b0010, 6'b000110, 1'b0, 32'h00000020, 32'h00001234, 32'd0);
    checks++;
    if (Result !== 32'h00001234) begin fails++; $display("FAIL srl_zero_amt got=%h exp=00001234", Result); end
    drive(4'b0010, 6'b000111, 1'b0, 32'hFFFFFFE1, 32'h80000000, 32'd0);
    checks++;
    if (Result !== 32'hC0000000) begin fails++; $display("FAIL sra_upper_ign got=%h exp=c0000000", Result); end
  endtask

  task automatic test_lui_default;
    drive(4'b0111, 6'b000000, 1'b1, 32'h0000ABCD, 32'd0, 32'h00001234);
    checks++;
    if (AluAddress !== 4'b1101 || Result !== 32'h12340000) begin
      fails++; $display("FAIL lui got=%b/%h exp=1101/12340000", AluAddress, Result);
    end
    drive(4'b1111, 6'b000000, 1'b0, 32'd2, 32'd3, 32'd0);
    checks++;
    if (AluAddress !== 4'b0010 || Result !== 32'd5) begin
      fails++; $display("FAIL aluop_default got=%b/%h exp=0010/5", AluAddress, Result);
    end
    drive(4'b0010, 6'b111111, 1'b0, 32'd2, 32'd3, 32'd0);
    checks++;
    if (AluAddress !== 4'b0010 || Result !== 32'd5) begin
      fails++; $display("FAIL funct_default got=%b/%h exp=0010/5", AluAddress, Result);
    end
    drive(4'b0110, 6'b000000, 1'b0, 32'h0000000F, 32'h000000FF, 32'd0);
    checks++;
    if (AluAddress !== 4'b0011 || Result !== 32'h000000F0) begin
      fails++; $display("FAIL xor_op got=%b/%h exp=0011/000000f0", AluAddress, Result);
    end
    drive(4'b0100, 6'b000000, 1'b0, 32'h0000000F, 32'h000000F0, 32'd0);
    checks++;
    if (AluAddress !== 4'b0001 || Result !== 32'h000000FF) begin
      fails++; $display("FAIL or_op got=%b/%h exp=0001/000000ff", AluAddress, Result);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_r [3];
    logic        exp_z [3];
    exp_r[0] = 32'd9;  exp_z[0] = 1'b0;
    exp_r[1] = 32'd0;  exp_z[1] = 1'b1;
    exp_r[2] = 32'h00000100; exp_z[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      case (i)
        0: drive(4'b0000, 6'b000000, 1'b0, 32'd4, 32'd5, 32'd0);
        1: drive(4'b0001, 6'b000000, 1'b0, 32'd6, 32'd6, 32'd0);
        default: drive(4'b0010, 6'b000100, 1'b0, 32'd8, 32'd1, 32'd0);
      endcase
      @(posedge clk); #1;
      checks++;
      if (Result_q !== exp_r[i] || Zero_q !== exp_z[i] || Overflow_q !== 1'b0) begin
        fails++; $display("FAIL b2b_%0d got=%h/%b/%b exp=%h/%b/0", i, Result_q, Zero_q, Overflow_q, exp_r[i], exp_z[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    Reset  = 1'b1;
    AluOp = 4'b0000; Funct = 6'b000000; AluSrc = 1'b0;
    Read_Data1 = 32'd0; Read_Data2 = 32'd0; Extention_out = 32'd0;
    test_reset();
    test_rtype();
    test_immediate();
    test_overflow();
    test_compare();
    test_shift();
    test_lui_default();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
